// File: rtl/cpu_datapath.sv
// Register-and-ALU datapath: accumulator A, register B, output register OUT and carry/zero
// flags, all loaded from one shared ALU result under per-register write strobes.
module cpu_datapath #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [3:0]       F,
   input  logic [1:0]       B_sel,
   input  logic             write_a,
   input  logic             write_b,
   input  logic             write_o,
   input  logic             write_cz,
   input  logic [WIDTH-1:0] ext_in,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b,
   output logic [WIDTH-1:0] reg_out,
   output logic             carry,
   output logic             zero
);

   typedef enum logic [3:0] {
      OP_PASS_A = 4'd0,
      OP_PASS_B = 4'd1,
      OP_INC_A  = 4'd2,
      OP_INC_B  = 4'd3,
      OP_ADD    = 4'd4,
      OP_SUB    = 4'd5,
      OP_AND    = 4'd6,
      OP_OR     = 4'd7,
      OP_SHR    = 4'd8,
      OP_SHL    = 4'd9
   } alu_op_e;

   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

   logic [WIDTH-1:0] bbus;
   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   wide;
   logic             co;
   logic             zo;

   // Unknown or unused selector codes fall to zero, so an X select never reaches ops that ignore B.
   always_comb begin
      case (B_sel)
         2'b00:   bbus = reg_b;
         2'b11:   bbus = ext_in;
         default: bbus = '0;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      wide = '0;
      res  = reg_a;
      co   = 1'b0;
      case (F)
         OP_PASS_A: res = reg_a;
         OP_PASS_B: res = bbus;
         OP_INC_A: begin
            wide = {1'b0, reg_a} + ONE;
            {co, res} = wide;
         end
         OP_INC_B: begin
            wide = {1'b0, bbus} + ONE;
            {co, res} = wide;
         end
         OP_ADD: begin
            wide = {1'b0, reg_a} + {1'b0, bbus};
            {co, res} = wide;
         end
         OP_SUB: begin
            // The extra MSB of a zero-extended subtract is exactly the borrow (A < B).
            wide = {1'b0, reg_a} - {1'b0, bbus};
            {co, res} = wide;
         end
         OP_AND: res = reg_a & bbus;
         OP_OR:  res = reg_a | bbus;
         OP_SHR: begin
            res = {1'b0, reg_a[WIDTH-1:1]};
            co  = reg_a[0];
         end
         OP_SHL: begin
            res = {reg_a[WIDTH-2:0], 1'b0};
            co  = reg_a[WIDTH-1];
         end
         default: begin
            res = reg_a;
            co  = 1'b0;
         end
      endcase
   end

   assign zo = (res == '0);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge A and B.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         reg_a   <= '0;
         reg_b   <= '0;
         reg_out <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
      end else begin
         if (write_a)  reg_a   <= res;
         if (write_b)  reg_b   <= res;
         if (write_o)  reg_out <= res;
         if (write_cz) begin
            carry <= co;
            zero  <= zo;
         end
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath: stimulus pushes hand-computed register state into a
// scoreboard queue; a monitor pops and compares it just after each rising edge.
module tb_cpu_datapath;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] F;
   logic [1:0] B_sel;
   logic       write_a, write_b, write_o, write_cz;
   logic [3:0] ext_in;
   logic [3:0] reg_a, reg_b, reg_out;
   logic       carry, zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] o;
      logic       c;
      logic       z;
   } exp_t;

   exp_t sb[$];

   cpu_datapath #(.WIDTH(4)) dut (
      .clk(clk), .rstn(rstn), .F(F), .B_sel(B_sel),
      .write_a(write_a), .write_b(write_b), .write_o(write_o), .write_cz(write_cz),
      .ext_in(ext_in), .reg_a(reg_a), .reg_b(reg_b), .reg_out(reg_out),
      .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input exp_t e);
      check({e.name, ".reg_a"},   reg_a,   e.a);
      check({e.name, ".reg_b"},   reg_b,   e.b);
      check({e.name, ".reg_out"}, reg_out, e.o);
      check({e.name, ".carry"},   {3'b0, carry}, {3'b0, e.c});
      check({e.name, ".zero"},    {3'b0, zero},  {3'b0, e.z});
   endtask

   // Monitor: registered outputs settle just after the rising edge.
   always begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check_all(sb.pop_front());
   end

   // Drive one instruction on the falling edge and queue the state expected after the next rise.
   task automatic op(input string name, input logic [3:0] f, input logic [1:0] bsel,
                     input logic [3:0] ext, input logic wa, input logic wb, input logic wo,
                     input logic wcz, input logic [3:0] ea, input logic [3:0] eb,
                     input logic [3:0] eo, input logic ec, input logic ez);
      exp_t e;
      @(negedge clk);
      F = f; B_sel = bsel; ext_in = ext;
      write_a = wa; write_b = wb; write_o = wo; write_cz = wcz;
      e.name = name; e.a = ea; e.b = eb; e.o = eo; e.c = ec; e.z = ez;
      sb.push_back(e);
   endtask

   initial begin
      rstn = 1'b0;
      F = 4'd0; B_sel = 2'b00; ext_in = 4'd0;
      write_a = 0; write_b = 0; write_o = 0; write_cz = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      //  name          F   sel    ext  wa wb wo cz   A     B     O     c  z
      op("idle0",     4'd0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      op("ld_f",      4'd1, 2'b11, 4'hF, 1, 0, 0, 1, 4'hF, 4'h0, 4'h0, 0, 0);
      op("inc_wrap",  4'd2, 2'b00, 4'h0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 1);
      op("ld_a9",     4'd1, 2'b11, 4'h9, 1, 0, 0, 0, 4'h9, 4'h0, 4'h0, 1, 1);
      op("ld_b8",     4'd1, 2'b11, 4'h8, 0, 1, 0, 0, 4'h9, 4'h8, 4'h0, 1, 1);
      op("add_ovf",   4'd4, 2'b00, 4'h0, 1, 0, 0, 1, 4'h1, 4'h8, 4'h0, 1, 0);
      op("sub_brw",   4'd5, 2'b00, 4'h0, 1, 0, 0, 1, 4'h9, 4'h8, 4'h0, 1, 0);
      op("ld_ab5",    4'd1, 2'b11, 4'h5, 1, 1, 0, 0, 4'h5, 4'h5, 4'h0, 1, 0);
      op("sub_zero",  4'd5, 2'b00, 4'h0, 1, 0, 0, 1, 4'h0, 4'h5, 4'h0, 0, 1);
      op("ld_a9b",    4'd1, 2'b11, 4'h9, 1, 0, 0, 0, 4'h9, 4'h5, 4'h0, 0, 1);
      op("shl",       4'd9, 2'b00, 4'h0, 1, 0, 0, 1, 4'h2, 4'h5, 4'h0, 1, 0);
      op("shr1",      4'd8, 2'b00, 4'h0, 1, 0, 0, 1, 4'h1, 4'h5, 4'h0, 0, 0);
      op("shr2",      4'd8, 2'b00, 4'h0, 1, 0, 0, 1, 4'h0, 4'h5, 4'h0, 1, 1);
      op("ld_a6",     4'd1, 2'b11, 4'h6, 1, 0, 0, 0, 4'h6, 4'h5, 4'h0, 1, 1);
      op("mov_ab",    4'd0, 2'b00, 4'h0, 0, 1, 0, 0, 4'h6, 4'h6, 4'h0, 1, 1);
      op("inc_b",     4'd3, 2'b00, 4'h0, 0, 1, 0, 0, 4'h6, 4'h7, 4'h0, 1, 1);
      op("out_a",     4'd0, 2'b00, 4'h0, 0, 0, 1, 0, 4'h6, 4'h7, 4'h6, 1, 1);
      op("ld_a3",     4'd1, 2'b11, 4'h3, 1, 0, 0, 0, 4'h3, 4'h7, 4'h6, 1, 1);
      op("ld_b2",     4'd1, 2'b11, 4'h2, 0, 1, 0, 0, 4'h3, 4'h2, 4'h6, 1, 1);
      op("add_all",   4'd4, 2'b00, 4'h0, 1, 1, 1, 0, 4'h5, 4'h5, 4'h5, 1, 1);
      op("op12",      4'd12,2'b00, 4'h0, 1, 0, 0, 1, 4'h5, 4'h5, 4'h5, 0, 0);
      op("sel01",     4'd1, 2'b01, 4'hF, 0, 1, 0, 1, 4'h5, 4'h0, 4'h5, 0, 1);
      op("sel10_inc", 4'd3, 2'b10, 4'hF, 0, 0, 1, 1, 4'h5, 4'h0, 4'h1, 0, 0);
      op("ld_b3",     4'd1, 2'b11, 4'h3, 0, 1, 0, 0, 4'h5, 4'h3, 4'h1, 0, 0);
      op("and",       4'd6, 2'b00, 4'h0, 0, 0, 1, 1, 4'h5, 4'h3, 4'h1, 0, 0);
      op("or",        4'd7, 2'b00, 4'h0, 0, 0, 1, 0, 4'h5, 4'h3, 4'h7, 0, 0);
      op("idle_hold", 4'd0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h5, 4'h3, 4'h7, 0, 0);

      // Asynchronous reset in the middle of the low phase, with a write pending.
      @(negedge clk);
      F = 4'd1; B_sel = 2'b11; ext_in = 4'hA; write_a = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst.reg_a",   reg_a,   4'h0);
      check("async_rst.reg_b",   reg_b,   4'h0);
      check("async_rst.reg_out", reg_out, 4'h0);
      check("async_rst.flags",   {2'b0, carry, zero}, 4'h0);
      begin
         exp_t e;
         e.name = "rst_held"; e.a = 4'h0; e.b = 4'h0; e.o = 4'h0; e.c = 1'b0; e.z = 1'b0;
         sb.push_back(e);
      end
      @(negedge clk);
      rstn = 1'b1;
      write_a = 1'b0;
      op("post_rst1", 4'd1, 2'b11, 4'hA, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      op("post_rst2", 4'd2, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
